// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default bit timing and byte width.
// Used by the receive front end, the transmitter and the MMIO peripheral.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 8802;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rxState_t;

    // Count at which the start bit is re-sampled near its centre.
    function automatic int halfBit(input int clksPerBit);
        return (clksPerBit - 1) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RST_VAL so an idle-high line never looks active out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front end: synchronises rx, validates the start bit at mid-bit,
// deserialises LSB first and strobes out clean bytes or framing errors.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              rxValid,
    output logic [DATA_W-1:0] rxData,
    output logic              frameErr,
    output logic              busy
);

    localparam int HALF_BIT = halfBit(CLKS_PER_BIT);
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

    logic              rxSync;
    rxState_t          state;
    rxState_t          stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    logic [2:0]        idx;
    logic [2:0]        idxNext;
    logic [DATA_W-1:0] shift;
    logic              sampleBit;
    logic              validNext;
    logic              errNext;

    // ---- Stage: input synchroniser (rx -> s1 -> s2) ----
    sync_2ff #(
        .RST_VAL(1'b1)
    ) rxSyncInst (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rxSync)
    );

    // ---- Stage: frame FSM, next-state and strobe decode ----
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        idxNext   = idx;
        sampleBit = 1'b0;
        validNext = 1'b0;
        errNext   = 1'b0;

        case (state)
            IDLE: begin
                cntNext = '0;
                idxNext = '0;
                if (!rxSync) begin
                    stateNext = START;
                end
            end

            START: begin
                if (cnt == CNT_HALF) begin
                    cntNext   = '0;
                    // A line that is high again at mid start bit was only a glitch.
                    stateNext = rxSync ? IDLE : DATA;
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    cntNext   = '0;
                    sampleBit = 1'b1;
                    if (idx == IDX_LAST) begin
                        idxNext   = '0;
                        stateNext = STOP;
                    end else begin
                        idxNext = idx + 3'd1;
                    end
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end

            STOP: begin
                if (cnt == CNT_LAST) begin
                    cntNext = '0;
                    if (rxSync) begin
                        validNext = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        errNext   = 1'b1;
                        stateNext = BREAK;
                    end
                end else begin
                    cntNext = cnt + CNT_ONE;
                end
            end

            BREAK: begin
                // Hold off until the line recovers so a stuck-low rx cannot retrigger.
                if (rxSync) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
                cntNext   = '0;
                idxNext   = '0;
            end
        endcase
    end

    // ---- Stage: state, counters and registered strobes ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            rxData   <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            idx      <= idxNext;
            rxValid  <= validNext;
            frameErr <= errNext;
            if (validNext) begin
                rxData <= shift;
            end
        end
    end

    // Shift register is pure data; every bit is rewritten before it is ever handed out.
    always_ff @(posedge clk) begin
        if (sampleBit && !rst) begin
            shift[idx] <= rxSync;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: frames are driven bit by bit, the expected
// strobe (kind, cycle, byte) is queued at stimulus time and checked by a monitor.
module tb_uart_rx_frontend;

    localparam int CPB     = 16;
    localparam int HALF    = (CPB - 1) / 2;
    localparam int LATENCY = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rxValid;
    logic       frameErr;
    logic       busy;
    logic [7:0] rxData;

    uart_rx_frontend #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rxValid (rxValid),
        .rxData  (rxData),
        .frameErr(frameErr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       isErr;
        logic [7:0] data;
        int         when;
    } expEvt_t;

    expEvt_t    expQ[$];
    expEvt_t    monEvt;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] lastGood    = 8'h00;
    logic [7:0] pat;
    logic [7:0] rndData;
    logic       rndStop;
    int         e0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic driveBit(input logic b, input int n);
        rx = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: a frame started now produces one strobe LATENCY edges after
    // the edge on which the synchroniser first sees the start bit.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        expEvt_t e;
        e.when = cyc + 1 + LATENCY;
        if (stopBit) begin
            e.isErr  = 1'b0;
            e.data   = data;
            lastGood = data;
        end else begin
            e.isErr = 1'b1;
            e.data  = lastGood;
        end
        expQ.push_back(e);
        driveBit(1'b0, CPB);
        for (int i = 0; i < 8; i++) driveBit(data[i], CPB);
        driveBit(stopBit, CPB);
    endtask

    task automatic busyAt(input int tgt, input logic exp, input string name);
        do @(negedge clk); while (cyc < tgt);
        chk(name, busy, exp);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (expQ.size() > 0 && expQ[0].when < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_strobe: nothing seen, want strobe at cycle %0d (now %0d)",
                     expQ[0].when, cyc);
            void'(expQ.pop_front());
        end
        if (rxValid === 1'b1 && frameErr === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_overlap: rxValid and frameErr both 1, want at most one (cycle %0d)", cyc);
        end
        if (rxValid === 1'b1 || frameErr === 1'b1) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: rxValid=%b frameErr=%b, want none (cycle %0d)",
                         rxValid, frameErr, cyc);
            end else begin
                monEvt = expQ.pop_front();
                chk("strobe_kind", frameErr, monEvt.isErr);
                chk("strobe_cycle", cyc, monEvt.when);
                chk("rxData", rxData, monEvt.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rxValid", rxValid, 1'b0);
        chk("reset_frameErr", frameErr, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rxData", rxData, 8'h00);
        rst = 1'b0;
        driveBit(1'b1, 5);

        // Single frame with busy-rise timing.
        e0 = cyc + 1;
        fork
            sendFrame(8'h55, 1'b1);
            begin
                busyAt(e0 + 1, 1'b0, "busy_before_rise");
                busyAt(e0 + 2, 1'b1, "busy_rise");
            end
        join
        driveBit(1'b1, 10);

        // Framing error followed by a held-low line, then a clean frame.
        sendFrame(8'hFF, 1'b0);
        driveBit(1'b0, 40);
        chk("busy_in_break", busy, 1'b1);
        driveBit(1'b1, 6);
        chk("busy_after_break", busy, 1'b0);
        chk("rxData_hold", rxData, 8'h55);
        driveBit(1'b1, 4);
        sendFrame(8'h12, 1'b1);
        driveBit(1'b1, 10);

        // Back-to-back frames, no idle gap.
        sendFrame(8'hA3, 1'b1);
        sendFrame(8'h00, 1'b1);
        driveBit(1'b1, 10);

        // False start: 4-cycle low pulse.
        e0 = cyc + 1;
        fork
            begin
                driveBit(1'b0, 4);
                driveBit(1'b1, 20);
            end
            begin
                busyAt(e0 + 2, 1'b1, "busy_false_start");
                busyAt(e0 + 12, 1'b0, "busy_after_glitch");
            end
        join

        // Reset in the middle of data bit 3.
        pat = 8'hC7;
        driveBit(1'b0, CPB);
        for (int i = 0; i < 3; i++) driveBit(pat[i], CPB);
        driveBit(pat[3], 6);
        chk("busy_mid_frame", busy, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lastGood = 8'h00;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rxData", rxData, 8'h00);
        chk("abort_rxValid", rxValid, 1'b0);
        chk("abort_frameErr", frameErr, 1'b0);
        driveBit(1'b1, 20);
        sendFrame(8'h81, 1'b1);
        driveBit(1'b1, 10);

        // Randomised frames, gaps and stop bits.
        for (int k = 0; k < 10; k++) begin
            rndData = 8'($urandom);
            rndStop = ($urandom_range(0, 3) != 0);
            sendFrame(rndData, rndStop);
            if (!rndStop) begin
                driveBit(1'b0, $urandom_range(0, 20));
                driveBit(1'b1, $urandom_range(2, 20));
            end else begin
                driveBit(1'b1, $urandom_range(0, 15));
            end
        end
        driveBit(1'b1, 2);

        for (int t = 0; t < 400 && expQ.size() > 0; t++) @(negedge clk);
        chk("queue_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
